antares_div_unit: RTL and testbench

ANTARES_DIV_UNIT -- requirements
Module: antares_div_unit

---
 rtl/antares_div_unit.sv | 119 +++++++++++
 tb/tb_antares_div_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/antares_div_unit.sv
// antares_div_unit: iterative 32-bit restoring divider for DIV/DIVU.
// Results are ready 34 edges after a start is accepted: 1 latch edge,
// 32 step edges and 1 sign-fix edge. A flush or reset aborts the
// operation and leaves the previous results unchanged.
module antares_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div_signed,
  input  logic        ex_div_unsigned,
  input  logic [31:0] ex_dividend,
  input  logic [31:0] ex_divisor,
  input  logic        ex_flush,
  output logic [31:0] div_quotient,
  output logic [31:0] div_remainder,
  output logic        div_busy,
  output logic        div_done,
  output logic        div_stall
);

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t      state;
  logic [63:0] acc;       // {partial remainder, dividend/quotient bits}
  logic [31:0] dvsr;
  logic        q_neg;
  logic        r_neg;
  logic [4:0]  cnt;

  logic        start_acc;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic        step_ok;
  logic [31:0] step_diff;

  // Start acceptance, operand magnitudes and the trial subtraction
  always_comb begin
    start_acc = (state == IDLE) & (ex_div_signed | ex_div_unsigned) & ~ex_flush;
    dvd_mag   = (ex_div_signed & ex_dividend[31]) ? -ex_dividend : ex_dividend;
    dvs_mag   = (ex_div_signed & ex_divisor[31])  ? -ex_divisor  : ex_divisor;
    // The shifted remainder is 33 bits wide. Its bit 32 comes from
    // acc[63]; if that bit is set, the trial subtraction cannot go
    // negative, and the 32-bit difference is exact.
    step_ok   = acc[63] | (acc[62:31] >= dvsr);
    step_diff = acc[62:31] - dvsr;
    div_stall = div_busy | start_acc;
  end

  // Divider FSM: latch operands, iterate 32 times, fix signs, publish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      acc           <= '0;
      dvsr          <= '0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      cnt           <= '0;
      div_quotient  <= '0;
      div_remainder <= '0;
      div_busy      <= 1'b0;
      div_done      <= 1'b0;
    end else begin
      div_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_acc) begin
            // A zero divisor runs the raw dividend with no sign fix.
            // Every trial step then succeeds, so the quotient becomes
            // all ones and the remainder is the original dividend.
            if (ex_divisor == '0) begin
              acc   <= {32'h0, ex_dividend};
              dvsr  <= '0;
              q_neg <= 1'b0;
              r_neg <= 1'b0;
            end else begin
              acc   <= {32'h0, dvd_mag};
              dvsr  <= dvs_mag;
              q_neg <= ex_div_signed & (ex_dividend[31] ^ ex_divisor[31]);
              r_neg <= ex_div_signed & ex_dividend[31];
            end
            cnt      <= 5'd31;
            div_busy <= 1'b1;
            state    <= DIV;
          end
        end
        DIV: begin
          if (ex_flush) begin
            div_busy <= 1'b0;
            state    <= IDLE;
          end else begin
            if (step_ok)
              acc <= {step_diff, acc[30:0], 1'b1};
            else
              acc <= {acc[62:0], 1'b0};
            cnt <= cnt - 5'd1;
            if (cnt == 5'd0)
              state <= FIX;
          end
        end
        FIX: begin
          if (ex_flush) begin
            div_busy <= 1'b0;
            state    <= IDLE;
          end else begin
            div_quotient  <= q_neg ? -acc[31:0]  : acc[31:0];
            div_remainder <= r_neg ? -acc[63:32] : acc[63:32];
            div_done      <= 1'b1;
            div_busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          div_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_antares_div_unit.sv
// Bench for antares_div_unit: directed and random divisions, flush,
// asynchronous reset and back-to-back starts, checked against
// plain-arithmetic expected values.
module tb_antares_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_div_signed;
  logic        ex_div_unsigned;
  logic [31:0] ex_dividend;
  logic [31:0] ex_divisor;
  logic        ex_flush;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        div_busy;
  logic        div_done;
  logic        div_stall;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  antares_div_unit dut (
    .clk            (clk),
    .rst            (rst),
    .ex_div_signed  (ex_div_signed),
    .ex_div_unsigned(ex_div_unsigned),
    .ex_dividend    (ex_dividend),
    .ex_divisor     (ex_divisor),
    .ex_flush       (ex_flush),
    .div_quotient   (div_quotient),
    .div_remainder  (div_remainder),
    .div_busy       (div_busy),
    .div_done       (div_done),
    .div_stall      (div_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference results computed with 64-bit integer arithmetic
  function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      return;
    end
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    lq = sa / sb;
    lr = sa % sb;
    q  = lq[31:0];
    r  = lr[31:0];
  endfunction

  // Full division: checks stall/busy/done timing and results.
  // poke>0 raises a spurious start before step edge 'poke'.
  task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input bit b2b, input int poke);
    logic [31:0] eq, er;
    ref_div(sgn, a, b, eq, er);
    @(negedge clk);
    ex_div_signed   = sgn;
    ex_div_unsigned = sgn ? 1'($urandom_range(0, 1)) : 1'b1;
    ex_dividend     = a;
    ex_divisor      = b;
    #1 chk("stall_on_start", {31'h0, div_stall}, 32'h1);
    @(posedge clk); #1;
    ex_div_signed   = 1'b0;
    ex_div_unsigned = 1'b0;
    chk("busy_T0", {31'h0, div_busy}, 32'h1);
    for (int c = 1; c <= 32; c++) begin
      if (c == poke) begin
        ex_div_unsigned = 1'b1;
        ex_dividend     = ~a;
        ex_divisor      = 32'h3;
      end
      @(posedge clk); #1;
      ex_div_unsigned = 1'b0;
      chk("busy_run", {31'h0, div_busy}, 32'h1);
      chk("stall_run", {31'h0, div_stall}, 32'h1);
      chk("done_early", {31'h0, div_done}, 32'h0);
      chk("q_hold", div_quotient, last_q);
    end
    @(posedge clk); #1;
    chk("done_T33", {31'h0, div_done}, 32'h1);
    chk("busy_T33", {31'h0, div_busy}, 32'h0);
    chk("quotient", div_quotient, eq);
    chk("remainder", div_remainder, er);
    last_q = eq;
    last_r = er;
    if (!b2b) begin
      @(posedge clk); #1;
      chk("done_pulse_width", {31'h0, div_done}, 32'h0);
    end
  endtask

  initial begin
    rst = 1'b1;
    ex_div_signed = 1'b0;
    ex_div_unsigned = 1'b0;
    ex_dividend = '0;
    ex_divisor = '0;
    ex_flush = 1'b0;
    #2;
    chk("rst_q", div_quotient, 32'h0);
    chk("rst_r", div_remainder, 32'h0);
    chk("rst_busy", {31'h0, div_busy}, 32'h0);
    chk("rst_done", {31'h0, div_done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    do_div(1'b0, 32'd100, 32'd7, 1'b0, 0);
    chk("divu_100_7_q", div_quotient, 32'd14);
    chk("divu_100_7_r", div_remainder, 32'd2);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    chk("div_m7_2_q", div_quotient, 32'hFFFF_FFFD);
    chk("div_m7_2_r", div_remainder, 32'hFFFF_FFFF);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 0);
    chk("div_7_m2_r", div_remainder, 32'h1);
    do_div(1'b0, 32'h1234_5678, 32'h0, 1'b0, 0);
    do_div(1'b1, 32'h8765_4321, 32'h0, 1'b0, 0);
    chk("div0_signed_r", div_remainder, 32'h8765_4321);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    chk("ovf_q", div_quotient, 32'h8000_0000);

    // Restore 14/2, then flush mid-run with a spurious start before it
    do_div(1'b0, 32'd100, 32'd7, 1'b0, 5);
    @(negedge clk);
    ex_div_unsigned = 1'b1;
    ex_dividend = 32'd50;
    ex_divisor = 32'd3;
    @(posedge clk); #1;
    ex_div_unsigned = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    ex_flush = 1'b1;
    @(posedge clk); #1;
    ex_flush = 1'b0;
    chk("flush_busy", {31'h0, div_busy}, 32'h0);
    chk("flush_stall", {31'h0, div_stall}, 32'h0);
    chk("flush_q", div_quotient, 32'd14);
    chk("flush_r", div_remainder, 32'd2);
    for (int i = 0; i < 36; i++) begin
      @(posedge clk); #1;
      chk("flush_no_done", {31'h0, div_done}, 32'h0);
    end

    // Flush together with a start in IDLE: no acceptance
    @(negedge clk);
    ex_div_signed = 1'b1;
    ex_flush = 1'b1;
    ex_dividend = 32'd9;
    ex_divisor = 32'd2;
    #1 chk("flush_start_stall", {31'h0, div_stall}, 32'h0);
    @(posedge clk); #1;
    ex_div_signed = 1'b0;
    ex_flush = 1'b0;
    chk("flush_start_busy", {31'h0, div_busy}, 32'h0);

    // Asynchronous reset at cycle 20 of a division
    @(negedge clk);
    ex_div_unsigned = 1'b1;
    ex_dividend = 32'd1000;
    ex_divisor = 32'd3;
    @(posedge clk); #1;
    ex_div_unsigned = 1'b0;
    repeat (20) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_q", div_quotient, 32'h0);
    chk("arst_r", div_remainder, 32'h0);
    chk("arst_busy", {31'h0, div_busy}, 32'h0);
    chk("arst_done", {31'h0, div_done}, 32'h0);
    rst = 1'b0;
    last_q = '0;
    last_r = '0;
    do_div(1'b0, 32'd9, 32'd3, 1'b0, 0);
    chk("divu_9_3_q", div_quotient, 32'd3);

    // Back-to-back: second start raised in the done cycle
    do_div(1'b0, 32'd1000, 32'd33, 1'b1, 0);
    do_div(1'b1, 32'hFFFF_FC18, 32'd7, 1'b0, 0);

    // Random operations
    for (int i = 0; i < 12; i++) begin
      logic [31:0] a, b;
      bit s;
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = $urandom_range(1, 15);
        2:       b = -$urandom_range(1, 15);
        3:       b = 32'h0;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      do_div(s, a, b, 1'($urandom_range(0, 1)), 0);
    end
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
